sram_2p_march_bist_ctrl: RTL and testbench

// - March C- BIST sequencer for one RM_IHPSG13_2P_<D>x<W> bm_bist macro. Drives the macro's A_BIST_* and B_BIST_* ports.
// - Tests port A over the full array, then port B. Records pass/fail and captures the first failing access.
// - Sits beside the macro in the memory wrapper; the macro's A/B_BIST_CLK are tied to CLK at wrapper level.

---
 rtl/sram_bist_pkg.sv | 31 +++
 rtl/sram_bist_addr_gen.sv | 28 ++
 rtl/sram_2p_march_bist_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sram_2p_march_bist_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the two-port SRAM BIST sequencer.
// Tables are indexed by march_elem_e (bit/entry i describes element Mi).
package sram_bist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    typedef enum logic {
        OP_R = 1'b0,
        OP_W = 1'b1
    } op_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 dn r0,w1; M4 dn r1,w0; M5 up r0
    localparam logic [5:0] ELEM_DIR      = 6'b011000;  // 1 = descending
    localparam logic [1:0] ELEM_NOPS [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [5:0] ELEM_RVAL     = 6'b010100;
    localparam logic [5:0] ELEM_WVAL     = 6'b001010;
    localparam op_e        ELEM_OP0  [6] = '{OP_W, OP_R, OP_R, OP_R, OP_R, OP_R};

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the March sequencer: loads 0 or N-1, steps in the
// current element direction and flags the terminal address of that direction.
module sram_bist_addr_gen #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_dn,
    input  logic              step,
    input  logic              dn,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_dn ? '1 : '0;
        end else if (step) begin
            addr <= dn ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    assign tc = dn ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST sequencer for a two-port bm_bist SRAM macro: runs port A, then
// port B, back to back, and captures the first miscompare.
module sram_2p_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W = 9,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic              FAIL_PORT,
    output logic [2:0]        FAIL_ELEM,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [DATA_W-1:0] FAIL_SYN,
    output logic              A_BIST_EN,
    output logic              A_BIST_MEN,
    output logic              A_BIST_WEN,
    output logic              A_BIST_REN,
    output logic [ADDR_W-1:0] A_BIST_ADDR,
    output logic [DATA_W-1:0] A_BIST_DIN,
    output logic [DATA_W-1:0] A_BIST_BM,
    input  logic [DATA_W-1:0] A_DOUT,
    output logic              B_BIST_EN,
    output logic              B_BIST_MEN,
    output logic              B_BIST_WEN,
    output logic              B_BIST_REN,
    output logic [ADDR_W-1:0] B_BIST_ADDR,
    output logic [DATA_W-1:0] B_BIST_DIN,
    output logic [DATA_W-1:0] B_BIST_BM,
    input  logic [DATA_W-1:0] B_DOUT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic              en;
        logic              men;
        logic              wen;
        logic              ren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] bm;
    } port_ctl_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] exp;
        port_e             port;
        march_elem_e       elem;
        logic [ADDR_W-1:0] addr;
    } cmp_t;

    logic [1:0]        state_q;
    port_e             port_q;
    march_elem_e       elem_q;
    logic              phase_q;
    logic              drain_q;
    port_ctl_t         a_q, b_q, a_d, b_d, op_ctl;
    cmp_t              cmp_s0, cmp_s1, cmp_d;

    logic              start_acc, two_op, rd_op, elem_last, run_last;
    march_elem_e       elem_nxt;
    logic [DATA_W-1:0] op_data, syn;
    logic              ag_load, ag_load_dn, ag_step, ag_dn, ag_tc;
    logic [ADDR_W-1:0] addr;

    sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (CLK),
        .rst     (RST),
        .load    (ag_load),
        .load_dn (ag_load_dn),
        .step    (ag_step),
        .dn      (ag_dn),
        .addr    (addr),
        .tc      (ag_tc)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start_acc  = (state_q == ST_IDLE) && START;
        two_op     = (ELEM_NOPS[elem_q] == 2'd2);
        rd_op      = !phase_q && (ELEM_OP0[elem_q] == OP_R);
        elem_last  = (!two_op || phase_q) && ag_tc;
        run_last   = elem_last && (elem_q == M5) && (port_q == PORT_B);
        elem_nxt   = (elem_q == M5) ? M0 : march_elem_e'(elem_q + 3'd1);
        op_data    = (rd_op ? ELEM_RVAL[elem_q] : ELEM_WVAL[elem_q]) ? ~BG : BG;
        ag_dn      = ELEM_DIR[elem_q];
        ag_load    = start_acc || ((state_q == ST_RUN) && elem_last && !run_last);
        ag_load_dn = start_acc ? ELEM_DIR[M0] : ELEM_DIR[elem_nxt];
        ag_step    = (state_q == ST_RUN) && (!two_op || phase_q) && !ag_tc;

        op_ctl      = '0;
        op_ctl.en   = 1'b1;
        op_ctl.men  = 1'b1;
        op_ctl.wen  = !rd_op;
        op_ctl.ren  = rd_op;
        op_ctl.addr = addr;
        op_ctl.din  = op_data;
        op_ctl.bm   = {DATA_W{!rd_op}};

        a_d = '0;
        b_d = '0;
        if (state_q == ST_RUN) begin
            if (port_q == PORT_A) a_d = op_ctl;
            else                  b_d = op_ctl;
        end else if (state_q == ST_DRAIN) begin
            b_d.en = !drain_q;
        end

        cmp_d       = '0;
        cmp_d.valid = (state_q == ST_RUN) && rd_op;
        cmp_d.exp   = op_data;
        cmp_d.port  = port_q;
        cmp_d.elem  = elem_q;
        cmp_d.addr  = addr;

        syn = ((cmp_s1.port == PORT_B) ? B_DOUT : A_DOUT) ^ cmp_s1.exp;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            port_q  <= PORT_A;
            elem_q  <= M0;
            phase_q <= 1'b0;
            drain_q <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q <= ST_RUN;
                        BUSY    <= 1'b1;
                        DONE    <= 1'b0;
                        port_q  <= PORT_A;
                        elem_q  <= M0;
                        phase_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (two_op && !phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (run_last) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 1'b0;
                        end else if (elem_last) begin
                            elem_q <= elem_nxt;
                            if (elem_q == M5) port_q <= PORT_B;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= ST_IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Read issued at edge k+1 is sampled by the macro at k+2 and checked here at k+3.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmp_s0    <= '0;
            cmp_s1    <= '0;
            FAIL      <= 1'b0;
            FAIL_PORT <= 1'b0;
            FAIL_ELEM <= '0;
            FAIL_ADDR <= '0;
            FAIL_SYN  <= '0;
        end else begin
            cmp_s0 <= cmp_d;
            cmp_s1 <= cmp_s0;
            if (start_acc) begin
                FAIL      <= 1'b0;
                FAIL_PORT <= 1'b0;
                FAIL_ELEM <= '0;
                FAIL_ADDR <= '0;
                FAIL_SYN  <= '0;
            end else if (cmp_s1.valid && (syn != '0)) begin
                FAIL <= 1'b1;
                if (!FAIL) begin
                    FAIL_PORT <= cmp_s1.port;
                    FAIL_ELEM <= cmp_s1.elem;
                    FAIL_ADDR <= cmp_s1.addr;
                    FAIL_SYN  <= syn;
                end
            end
        end
    end

    assign A_BIST_EN   = a_q.en;
    assign A_BIST_MEN  = a_q.men;
    assign A_BIST_WEN  = a_q.wen;
    assign A_BIST_REN  = a_q.ren;
    assign A_BIST_ADDR = a_q.addr;
    assign A_BIST_DIN  = a_q.din;
    assign A_BIST_BM   = a_q.bm;
    assign B_BIST_EN   = b_q.en;
    assign B_BIST_MEN  = b_q.men;
    assign B_BIST_WEN  = b_q.wen;
    assign B_BIST_REN  = b_q.ren;
    assign B_BIST_ADDR = b_q.addr;
    assign B_BIST_DIN  = b_q.din;
    assign B_BIST_BM   = b_q.bm;

endmodule

// File: tb/tb_sram_2p_march_bist_ctrl.sv
// Directed bench for the March C- BIST sequencer with a two-port memory model
// that can inject a port-A stuck-at bit and a port-B write coupling fault.
module tb_sram_2p_march_bist_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int RUN_CYC = 10242;

    logic              CLK = 1'b0;
    logic              RST, START;
    logic              BUSY, DONE, FAIL, FAIL_PORT;
    logic [2:0]        FAIL_ELEM;
    logic [ADDR_W-1:0] FAIL_ADDR;
    logic [DATA_W-1:0] FAIL_SYN;
    logic              A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [ADDR_W-1:0] A_BIST_ADDR;
    logic [DATA_W-1:0] A_BIST_DIN, A_BIST_BM, A_DOUT;
    logic              B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN;
    logic [ADDR_W-1:0] B_BIST_ADDR;
    logic [DATA_W-1:0] B_BIST_DIN, B_BIST_BM, B_DOUT;

    sram_2p_march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BG(8'h00)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .FAIL        (FAIL),
        .FAIL_PORT   (FAIL_PORT),
        .FAIL_ELEM   (FAIL_ELEM),
        .FAIL_ADDR   (FAIL_ADDR),
        .FAIL_SYN    (FAIL_SYN),
        .A_BIST_EN   (A_BIST_EN),
        .A_BIST_MEN  (A_BIST_MEN),
        .A_BIST_WEN  (A_BIST_WEN),
        .A_BIST_REN  (A_BIST_REN),
        .A_BIST_ADDR (A_BIST_ADDR),
        .A_BIST_DIN  (A_BIST_DIN),
        .A_BIST_BM   (A_BIST_BM),
        .A_DOUT      (A_DOUT),
        .B_BIST_EN   (B_BIST_EN),
        .B_BIST_MEN  (B_BIST_MEN),
        .B_BIST_WEN  (B_BIST_WEN),
        .B_BIST_REN  (B_BIST_REN),
        .B_BIST_ADDR (B_BIST_ADDR),
        .B_BIST_DIN  (B_BIST_DIN),
        .B_BIST_BM   (B_BIST_BM),
        .B_DOUT      (B_DOUT)
    );

    always #5 CLK = ~CLK;

    // Memory model: registered read, bit-masked write, optional faults.
    logic [DATA_W-1:0] mem [512];
    logic              sa_en, cf_en;
    int                cf_cnt;

    always @(posedge CLK) begin
        if (A_BIST_EN && A_BIST_MEN) begin
            if (A_BIST_WEN)
                mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
            if (A_BIST_REN)
                A_DOUT <= mem[A_BIST_ADDR] | ((sa_en && A_BIST_ADDR == 9'h0A5) ? 8'h08 : 8'h00);
        end
        if (!cf_en) cf_cnt <= 0;
        if (B_BIST_EN && B_BIST_MEN) begin
            if (B_BIST_WEN) begin
                mem[B_BIST_ADDR] <= (mem[B_BIST_ADDR] & ~B_BIST_BM) | (B_BIST_DIN & B_BIST_BM);
                // Second w1 to 0x100 on port B is the M3 write; it disturbs 0x0FF bit 0.
                if (cf_en && B_BIST_ADDR == 9'h100 && B_BIST_DIN == 8'hFF) begin
                    cf_cnt <= cf_cnt + 1;
                    if (cf_cnt == 1) mem[9'h0FF] <= mem[9'h0FF] ^ 8'h01;
                end
            end
            if (B_BIST_REN) B_DOUT <= mem[B_BIST_ADDR];
        end
    end

    int n_vec = 0;
    int n_miss = 0;
    int done_cyc, busy_cnt, viol;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] status_v();
        return 64'({BUSY, DONE, FAIL, FAIL_PORT, FAIL_ELEM, FAIL_ADDR, FAIL_SYN});
    endfunction

    function automatic logic [63:0] port_a_v();
        return 64'({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM});
    endfunction

    function automatic logic [63:0] port_b_v();
        return 64'({B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN, B_BIST_ADDR, B_BIST_DIN, B_BIST_BM});
    endfunction

    // Expected port activity at selected edges after START acceptance (edge 0).
    task automatic trace_check(input int cyc);
        case (cyc)
            1:     check("m0_a_first_w0", port_a_v(), 64'({4'b1110, 9'h000, 8'h00, 8'hFF}));
            513:   check("m1_a_first_r0",
                         64'({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_BM}),
                         64'({4'b1101, 9'h000, 8'h00}));
            514:   check("m1_a_first_w1", port_a_v(), 64'({4'b1110, 9'h000, 8'hFF, 8'hFF}));
            2561:  check("m3_a_first_addr",
                         64'({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR}),
                         64'({4'b1101, 9'h1FF}));
            3584:  check("m3_a_last_addr",
                         64'({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR}),
                         64'({4'b1110, 9'h000}));
            5120:  check("m5_a_last_read",
                         64'({A_BIST_EN, A_BIST_REN, B_BIST_EN, A_BIST_ADDR}),
                         64'({3'b110, 9'h1FF}));
            5121:  check("m0_b_first_w0", 64'({A_BIST_EN, port_b_v()[28:0]}),
                         64'({1'b0, 4'b1110, 9'h000, 8'h00, 8'hFF}));
            10240: check("m5_b_last_read",
                         64'({B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN, B_BIST_ADDR, BUSY, DONE}),
                         64'({4'b1101, 9'h1FF, 2'b10}));
            10241: check("drain_b",
                         64'({B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN, A_BIST_EN, BUSY, DONE}),
                         64'({4'b1000, 3'b010}));
            default: ;
        endcase
    endtask

    // Pulse START at edge 0, then watch until DONE (bounded), optionally
    // re-pulsing START or asserting RST on a chosen edge.
    task automatic run_bist(input bit trace, input int pulse_at, input int rst_at);
        int cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("accept_status", status_v(), 64'({1'b1, 23'd0}));
        done_cyc = -1;
        busy_cnt = 0;
        viol     = 0;
        cyc      = 0;
        while (cyc < 12000) begin
            if (BUSY) busy_cnt++;
            if ((A_BIST_REN && A_BIST_WEN) || (B_BIST_REN && B_BIST_WEN) || (A_BIST_EN && B_BIST_EN))
                viol++;
            if (trace) trace_check(cyc);
            if (DONE) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == rst_at) break;
            START = (cyc + 1 == pulse_at);
            RST   = (cyc + 1 == rst_at);
            tick();
            cyc++;
        end
        START = 1'b0;
        RST   = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        sa_en = 1'b0;
        cf_en = 1'b0;
        repeat (3) tick();
        check("rst_status", status_v(), 64'd0);
        check("rst_port_a", port_a_v(), 64'd0);
        check("rst_port_b", port_b_v(), 64'd0);
        RST = 1'b0;
        tick();
        check("idle_status", status_v(), 64'd0);

        // Clean run with address/port trace.
        run_bist(1'b1, -1, -1);
        check("clean_done_cyc", 64'(done_cyc), 64'(RUN_CYC));
        check("clean_busy_cnt", 64'(busy_cnt), 64'(RUN_CYC));
        check("clean_no_overlap", 64'(viol), 64'd0);
        check("clean_status", status_v(), 64'({3'b010, 21'd0}));
        check("clean_port_b_idle", port_b_v(), 64'd0);

        // Stuck-at-1 bit 3 at 0x0A5 on port A: repeated misses, first one kept.
        sa_en = 1'b1;
        run_bist(1'b0, -1, -1);
        sa_en = 1'b0;
        check("sa_done_cyc", 64'(done_cyc), 64'(RUN_CYC));
        check("sa_fail", 64'(FAIL), 64'd1);
        check("sa_fail_port", 64'(FAIL_PORT), 64'd0);
        check("sa_fail_elem", 64'(FAIL_ELEM), 64'd1);
        check("sa_fail_addr", 64'(FAIL_ADDR), 64'h0A5);
        check("sa_fail_syn", 64'(FAIL_SYN), 64'h08);

        // Coupling fault on port B during M3; START also clears the previous failure.
        cf_en = 1'b1;
        run_bist(1'b0, -1, -1);
        cf_en = 1'b0;
        check("cf_done_cyc", 64'(done_cyc), 64'(RUN_CYC));
        check("cf_fail", 64'(FAIL), 64'd1);
        check("cf_fail_port", 64'(FAIL_PORT), 64'd1);
        check("cf_fail_elem", 64'(FAIL_ELEM), 64'd3);
        check("cf_fail_addr", 64'(FAIL_ADDR), 64'h0FF);
        check("cf_fail_syn", 64'(FAIL_SYN), 64'h01);

        // START re-pulsed while busy must not disturb the run.
        run_bist(1'b0, 500, -1);
        check("busy_start_done_cyc", 64'(done_cyc), 64'(RUN_CYC));
        check("busy_start_busy_cnt", 64'(busy_cnt), 64'(RUN_CYC));
        check("busy_start_fail", 64'(FAIL), 64'd0);

        // Reset in the middle of a run, then a fresh run.
        run_bist(1'b0, -1, 3000);
        check("midrst_status", status_v(), 64'd0);
        check("midrst_port_a", port_a_v(), 64'd0);
        check("midrst_port_b", port_b_v(), 64'd0);
        tick();
        run_bist(1'b0, -1, -1);
        check("after_rst_done_cyc", 64'(done_cyc), 64'(RUN_CYC));
        check("after_rst_status", status_v(), 64'({3'b010, 21'd0}));
        check("after_rst_no_overlap", 64'(viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
